// File: rtl/hex_rotate_ctrl_pkg.sv
// Shared types and constants for the hex display rotation controller.
// Debounce length DB_CYC applies only when HEX_ROTATE_DEBOUNCE_EN is defined.
package hex_rotate_ctrl_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DB_CYC = 1000000;

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/key_press_pulse.sv
// Raw active-low pushbutton to single-cycle press pulse: 2-FF synchronizer, optional
// debounce (HEX_ROTATE_DEBOUNCE_EN) and falling-edge detector.
module key_press_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic [1:0] sync_q;
  logic [2:0] prime_q;
  logic       prev_q;
  logic       level;
  logic       valid;

  // The edge detector stays disarmed until the synchronizer holds real samples, so a
  // button held through reset release reads as "already pressed" rather than a new press.
  assign valid = prime_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      prime_q <= 3'b000;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      prime_q <= {prime_q[1:0], 1'b1};
      if (valid) begin
        prev_q <= level;
      end
    end
  end

`ifdef HEX_ROTATE_DEBOUNCE_EN
  import hex_rotate_ctrl_pkg::*;

  localparam int unsigned DB_W = $clog2(DB_CYC);

  logic            db_q;
  logic [DB_W-1:0] db_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q     <= 1'b1;
      db_cnt_q <= '0;
    end else if (!valid) begin
      db_q     <= sync_q[1];
      db_cnt_q <= '0;
    end else if (sync_q[1] == db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_W'(DB_CYC - 1)) begin
      db_q     <= sync_q[1];
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DB_W'(1);
    end
  end

  assign level = db_q;
`else
  assign level = sync_q[1];
`endif

  assign press = valid & prev_q & ~level;

endmodule

// File: rtl/hex_rotate_ctrl.sv
// Timed, button-controlled rotation index for the six HEX display select muxes.
// Optional key debounce is enabled with HEX_ROTATE_DEBOUNCE_EN.
module hex_rotate_ctrl
  import hex_rotate_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int unsigned CNT_W    = 25,
  parameter int unsigned NUM_POS  = 6
) (
  input  logic             CLOCK_50,
  input  logic             Resetn,
  input  logic             run_key_n,
  input  logic             step_key_n,
  input  logic             dir,
  output logic [SEL_W-1:0] sel,
  output logic             tick,
  output logic             running
);

  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] LastPos = SEL_W'(NUM_POS - 1);

  logic run_press;
  logic step_press;

  key_press_pulse u_run_key (
    .clk   (CLOCK_50),
    .rst_n (Resetn),
    .key_n (run_key_n),
    .press (run_press)
  );

  key_press_pulse u_step_key (
    .clk   (CLOCK_50),
    .rst_n (Resetn),
    .key_n (step_key_n),
    .press (step_press)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             tick_q;
  logic             advance;

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_PAUSE;
      presc_q <= '0;
      sel_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
      tick_q  <= advance;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    advance = 1'b0;
    unique case (state_q)
      ST_PAUSE: begin
        presc_d = '0;
        // Run beats a simultaneous step; the step is dropped.
        if (run_press) begin
          state_d = ST_RUN;
        end else if (step_press) begin
          advance = 1'b1;
        end
      end
      ST_RUN: begin
        if (presc_q == TermCnt) begin
          presc_d = '0;
          advance = 1'b1;
        end else begin
          presc_d = presc_q + CNT_W'(1);
        end
        // A pause landing on the terminal count still lets that advance happen.
        if (run_press) begin
          state_d = ST_PAUSE;
          presc_d = '0;
        end
      end
      default: begin
        state_d = ST_PAUSE;
        presc_d = '0;
      end
    endcase
  end

  always_comb begin
    sel_d = sel_q;
    if (advance) begin
      if (dir) begin
        sel_d = (sel_q == '0) ? LastPos : sel_q - SEL_W'(1);
      end else begin
        sel_d = (sel_q == LastPos) ? '0 : sel_q + SEL_W'(1);
      end
    end
  end

  assign sel     = sel_q;
  assign tick    = tick_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_hex_rotate_ctrl.sv
// Self-checking bench for hex_rotate_ctrl with TICK_DIV=4, NUM_POS=6, no debounce.
module tb_hex_rotate_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run_key_n;
  logic       step_key_n;
  logic       dir;
  logic [2:0] sel;
  logic       tick;
  logic       running;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] sel;
    int         cyc;
  } exp_t;

  typedef struct {
    logic       dir;
    logic [2:0] exp_sel;
  } step_vec_t;

  exp_t      exp_q[$];
  step_vec_t steps[7];

  hex_rotate_ctrl #(
    .TICK_DIV (4),
    .CNT_W    (3),
    .NUM_POS  (6)
  ) dut (
    .CLOCK_50   (clk),
    .Resetn     (rst_n),
    .run_key_n  (run_key_n),
    .step_key_n (step_key_n),
    .dir        (dir),
    .sel        (sel),
    .tick       (tick),
    .running    (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every tick must match the oldest expected (sel, cycle) entry.
  always @(negedge clk) begin
    if (tick !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got tick=%b sel=%0d, expected no tick (cycle %0d)",
                 tick, sel, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tick_sel", int'(sel), int'(e.sel));
        check("tick_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_exp(input logic [2:0] s, input int c);
    exp_t e;
    e.sel = s;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic press_key(input bit is_step, output int start);
    start = cyc;
    if (is_step) step_key_n = 1'b0;
    else run_key_n = 1'b0;
    repeat (4) @(negedge clk);
    step_key_n = 1'b1;
    run_key_n  = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int m;
    int p;

    steps[0] = '{dir: 1'b0, exp_sel: 3'd1};
    steps[1] = '{dir: 1'b0, exp_sel: 3'd2};
    steps[2] = '{dir: 1'b0, exp_sel: 3'd3};
    steps[3] = '{dir: 1'b0, exp_sel: 3'd4};
    steps[4] = '{dir: 1'b0, exp_sel: 3'd5};
    steps[5] = '{dir: 1'b0, exp_sel: 3'd0};
    steps[6] = '{dir: 1'b0, exp_sel: 3'd1};

    rst_n      = 1'b0;
    run_key_n  = 1'b1;
    step_key_n = 1'b1;
    dir        = 1'b0;
    #1;
    check("reset_sel", int'(sel), 0);
    check("reset_running", int'(running), 0);
    check("reset_tick", int'(tick), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle: the scoreboard flags any tick.
    repeat (50) @(negedge clk);
    check("idle_sel", int'(sel), 0);
    check("idle_running", int'(running), 0);

    // Single steps while paused.
    for (int i = 0; i < 7; i++) begin
      dir = steps[i].dir;
      push_exp(steps[i].exp_sel, cyc + 3);
      press_key(1'b1, n);
    end
    wait_drain(10);
    check("steps_running", int'(running), 0);

    // Auto-run forward, ignored step, reverse, then pause on a terminal count.
    n = cyc;
    push_exp(3'd2, n + 7);
    push_exp(3'd3, n + 11);
    push_exp(3'd4, n + 15);
    push_exp(3'd5, n + 19);
    push_exp(3'd0, n + 23);
    push_exp(3'd5, n + 27);
    push_exp(3'd4, n + 31);
    push_exp(3'd3, n + 35);
    push_exp(3'd2, n + 39);
    press_key(1'b0, m);
    check("run_running", int'(running), 1);
    wait_until(n + 12);
    press_key(1'b1, m);
    wait_until(n + 24);
    dir = 1'b1;
    wait_until(n + 36);
    press_key(1'b0, m);
    check("paused_running", int'(running), 0);
    wait_until(n + 60);
    check("frozen_sel", int'(sel), 2);
    check("frozen_running", int'(running), 0);
    wait_drain(10);

    // Run and step together while paused: run wins, no advance.
    m = cyc;
    push_exp(3'd1, m + 7);
    push_exp(3'd0, m + 11);
    push_exp(3'd5, m + 15);
    push_exp(3'd4, m + 19);
    push_exp(3'd3, m + 23);
    run_key_n  = 1'b0;
    step_key_n = 1'b0;
    wait_until(m + 4);
    check("both_running", int'(running), 1);
    check("both_sel", int'(sel), 2);
    run_key_n  = 1'b1;
    step_key_n = 1'b1;

    // Reset mid-run (sel=3, prescaler=2) with the run key held through release.
    wait_until(m + 25);
    check("pre_reset_sel", int'(sel), 3);
    check("pre_reset_queue", exp_q.size(), 0);
    run_key_n = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrun_reset_sel", int'(sel), 0);
    check("midrun_reset_running", int'(running), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("held_key_running", int'(running), 0);
    check("held_key_sel", int'(sel), 0);
    run_key_n = 1'b1;
    repeat (6) @(negedge clk);

    p = cyc;
    push_exp(3'd5, p + 7);
    run_key_n = 1'b0;
    wait_until(p + 2);
    check("latency_before", int'(running), 0);
    wait_until(p + 3);
    check("latency_at", int'(running), 1);
    wait_until(p + 5);
    run_key_n = 1'b1;
    wait_drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_rotate_ctrl.md
Name: hex_rotate_ctrl

Overview:
- Sequential select generator that sits directly upstream of the six 3-bit 6-to-1 display muxes.
- It replaces the static KEY-driven select with a timed, button-controlled rotation index.
- Its sel output drives every mux select input, so the six-character message scrolls across HEX5..HEX0.
- It supports auto-scroll, pause, single-step and reversible direction.

Parameters:
- TICK_DIV, 25000000, clock cycles per auto-advance (0.5 s at 50 MHz); legal range 2..2^CNT_W.
- CNT_W, 25, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.
- NUM_POS, 6, number of rotation positions; sel counts 0..NUM_POS-1; legal range 2..8.

Ports:
- CLOCK_50  in   1  system clock, all state on rising edge.
- Resetn    in   1  asynchronous active-low reset.
- run_key_n in   1  raw pushbutton, active-low; each press toggles run/pause.
- step_key_n in  1  raw pushbutton, active-low; each press while paused advances one position.
- dir       in   1  0 = forward (sel+1), 1 = reverse (sel-1); level, sampled at each advance.
- sel       out  3  rotation index to the mux select inputs.
- tick      out  1  one-cycle pulse on every cycle in which sel advances, whether auto or step.
- running   out  1  1 while in RUN state.

Behaviour:
- Reset (async, Resetn=0):
  - sel=0, tick=0, running=0.
  - FSM enters PAUSE, prescaler is 0.
  - Synchronizer flops are preset to 1 (released button); edge detectors are cleared.
  - Takes effect immediately mid-operation, with no pending press retained.
- Button front end:
  - Each key passes through a 2-FF synchronizer, then a falling-edge detector, producing a 1-cycle press pulse.
  - Press-to-pulse latency is 3 clocks.
  - A held button yields exactly one pulse.
- FSM, two states:
  - PAUSE: prescaler held at 0. A step pulse advances sel and asserts tick in the same cycle as the update. A run pulse moves to RUN.
  - RUN: prescaler increments each cycle. When it reaches TICK_DIV-1 it wraps to 0, sel advances and tick=1. Step pulses are ignored. A run pulse moves to PAUSE.
  - The first auto-advance after entering RUN occurs exactly TICK_DIV cycles after the transition cycle.
- Advance arithmetic:
  - Forward: sel==NUM_POS-1 wraps to 0.
  - Reverse: sel==0 wraps to NUM_POS-1.
  - sel never leaves 0..NUM_POS-1.
  - dir is sampled only at the advance edge, so changing it between advances has no other effect.
- Simultaneous events:
  - Run and step pulses in the same cycle while in PAUSE: run wins, the step is dropped, and there is no advance.
  - Run pulse in the same cycle as the terminal count while in RUN: the advance and tick still occur that cycle, then the FSM moves to PAUSE with the prescaler cleared.
- Outputs are registered; sel and tick update on the same edge, and running reflects the state register.

Optional Feature:
- Macro: HEX_ROTATE_DEBOUNCE_EN.
- Defined:
  - Each synchronized key feeds a debounce counter of DB_CYC cycles (package constant, 1000000 = 20 ms at 50 MHz).
  - The debounced level changes only after the synced level has been stable for DB_CYC consecutive cycles. The edge detector operates on the debounced level.
  - Press latency becomes 3 + DB_CYC clocks.
  - Glitches shorter than DB_CYC produce no pulse.
- Undefined: no debounce logic; behaviour is exactly as described above.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_PAUSE=1'b0, ST_RUN=1'b1).
  - DB_CYC constant.
  - SEL_W=3.
- One natural sub-module, key_press_pulse:
  - Contains the synchronizer, the optional debounce and the falling-edge detector.
  - Instantiated twice, once per key.
- The FSM, prescaler and sel counter stay in the top module.

Test Plan (TICK_DIV=4, NUM_POS=6, macro undefined):
- Reset, then no key activity for 50 cycles -> sel=0, running=0, tick never 1.
- In PAUSE, dir=0, 7 step presses -> sel sequence 1,2,3,4,5,0,1. Each step yields one tick, appearing 3 cycles after the press.
- Run press, dir=0 -> running=1; tick every 4th cycle, first one 4 cycles after running rises; sel 1→2→3→4→5→0. A step press mid-run does not change sel.
- In RUN with sel=0, set dir=1 -> next advances give sel 5,4,3.
- Assert run and step presses in the same cycle while paused -> running=1 and sel unchanged. Separately, a run press landing on the terminal-count cycle -> sel advances once, then running=0 and sel is frozen.
- Assert Resetn=0 mid-run with sel=3 and the prescaler at 2 -> sel=0 and running=0 immediately. A button held through reset release produces no pulse until it is released and pressed again.
